// File: rtl/exc_pkg.sv
// Shared types and constants for the LEGv8 exception sequencer.
// Optional cause counters are enabled by defining EXC_CAUSE_COUNT_EN.
package exc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    VECTOR,
    HANDLER,
    RETURN
  } exc_state_t;

  localparam logic [3:0] ESR_NONE  = 4'b0000;
  localparam logic [3:0] ESR_IRQ   = 4'b0001;
  localparam logic [3:0] ESR_UNDEF = 4'b0010;

  localparam logic [63:0] DEFAULT_VECTOR_ADDR = 64'hD8;

  typedef struct packed {
    logic flush;
    logic pc_sel_vec;
    logic pc_sel_eret;
    logic exc_ack;
    logic in_handler;
  } exc_ctrl_t;

  // Registered control outputs to present while in a given state.
  function automatic exc_ctrl_t ctrl_for(exc_state_t s);
    exc_ctrl_t c;
    c = '0;
    case (s)
      FLUSH:   c.flush = 1'b1;
      VECTOR:  begin c.flush = 1'b1; c.pc_sel_vec = 1'b1; c.exc_ack = 1'b1; end
      HANDLER: c.in_handler = 1'b1;
      RETURN:  begin c.flush = 1'b1; c.pc_sel_eret = 1'b1; c.in_handler = 1'b1; end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/exc_flush_timer.sv
// Loadable down-counter; done marks the last flush cycle.
module exc_flush_timer #(
  parameter int unsigned CW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic          done
);

  logic [CW-1:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign done = (count_q == CW'(1));

endmodule

// File: rtl/exception_sequencer.sv
// Exception entry/return sequencer for the pipelined LEGv8 core.
// Define EXC_CAUSE_COUNT_EN to add saturating UndefCount/IrqCount outputs.
module exception_sequencer
  import exc_pkg::*;
#(
  parameter int unsigned   N            = 64,
  parameter int unsigned   FLUSH_CYCLES = 3,
  parameter logic [N-1:0]  VECTOR_ADDR  = N'(DEFAULT_VECTOR_ADDR)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         NotAnInstr,
  input  logic         ExtIRQ,
  input  logic         ERet,
  input  logic [N-1:0] PC_E,
  output logic         Flush,
  output logic         PCSelVec,
  output logic         PCSelERet,
  output logic [N-1:0] ExcVector,
  output logic [N-1:0] ERetPC,
  output logic [N-1:0] ELR,
  output logic [3:0]   ESR,
  output logic         ExcAck,
  output logic         ExtIAck,
`ifdef EXC_CAUSE_COUNT_EN
  output logic [15:0]  UndefCount,
  output logic [15:0]  IrqCount,
`endif
  output logic         InHandler
);

  localparam int unsigned CW = $clog2(FLUSH_CYCLES + 1);

  exc_state_t   state_q;
  exc_ctrl_t    ctrl_q;
  logic [3:0]   esr_q;
  logic [N-1:0] elr_q;
  logic         entry;
  logic         timer_done;

  assign entry = (state_q == IDLE) && (NotAnInstr || ExtIRQ);

  exc_flush_timer #(
    .CW(CW)
  ) u_flush_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (entry),
    .load_val(CW'(FLUSH_CYCLES)),
    .dec     (state_q == FLUSH),
    .done    (timer_done)
  );

  // Outputs are loaded together with the state they belong to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ctrl_q  <= '0;
      esr_q   <= ESR_NONE;
      elr_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (entry) begin
            state_q <= FLUSH;
            ctrl_q  <= ctrl_for(FLUSH);
            esr_q   <= NotAnInstr ? ESR_UNDEF : ESR_IRQ;
            elr_q   <= PC_E;
          end
        end
        FLUSH: begin
          if (timer_done) begin
            state_q <= VECTOR;
            ctrl_q  <= ctrl_for(VECTOR);
          end
        end
        VECTOR: begin
          state_q <= HANDLER;
          ctrl_q  <= ctrl_for(HANDLER);
        end
        HANDLER: begin
          if (ERet) begin
            state_q <= RETURN;
            ctrl_q  <= ctrl_for(RETURN);
          end
        end
        RETURN: begin
          state_q <= IDLE;
          ctrl_q  <= ctrl_for(IDLE);
        end
        default: begin
          state_q <= IDLE;
          ctrl_q  <= '0;
        end
      endcase
    end
  end

`ifdef EXC_CAUSE_COUNT_EN
  logic [15:0] undef_count_q;
  logic [15:0] irq_count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      undef_count_q <= '0;
      irq_count_q   <= '0;
    end else if (entry) begin
      if (NotAnInstr) begin
        if (undef_count_q != 16'hFFFF) undef_count_q <= undef_count_q + 16'd1;
      end else begin
        if (irq_count_q != 16'hFFFF) irq_count_q <= irq_count_q + 16'd1;
      end
    end
  end

  assign UndefCount = undef_count_q;
  assign IrqCount   = irq_count_q;
`endif

  assign Flush     = ctrl_q.flush;
  assign PCSelVec  = ctrl_q.pc_sel_vec;
  assign PCSelERet = ctrl_q.pc_sel_eret;
  assign ExcAck    = ctrl_q.exc_ack;
  assign InHandler = ctrl_q.in_handler;
  assign ExtIAck   = ctrl_q.exc_ack && (esr_q == ESR_IRQ);
  assign ExcVector = VECTOR_ADDR;
  assign ERetPC    = elr_q;
  assign ELR       = elr_q;
  assign ESR       = esr_q;

endmodule

// File: tb/tb_exception_sequencer.sv
// Self-checking bench for exception_sequencer: directed scenarios plus a random run
// against a cycle-offset reference model.
module tb_exception_sequencer;

  localparam int F = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        NotAnInstr;
  logic        ExtIRQ;
  logic        ERet;
  logic [63:0] PC_E;
  logic        Flush, PCSelVec, PCSelERet, ExcAck, ExtIAck, InHandler;
  logic [63:0] ExcVector, ERetPC, ELR;
  logic [3:0]  ESR;
`ifdef EXC_CAUSE_COUNT_EN
  logic [15:0] UndefCount, IrqCount;
`endif

  int total = 0;
  int bad = 0;

  // {Flush, PCSelVec, PCSelERet, ExcAck, ExtIAck, InHandler}
  logic [5:0] ctl;
  assign ctl = {Flush, PCSelVec, PCSelERet, ExcAck, ExtIAck, InHandler};

  exception_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .NotAnInstr(NotAnInstr),
    .ExtIRQ    (ExtIRQ),
    .ERet      (ERet),
    .PC_E      (PC_E),
    .Flush     (Flush),
    .PCSelVec  (PCSelVec),
    .PCSelERet (PCSelERet),
    .ExcVector (ExcVector),
    .ERetPC    (ERetPC),
    .ELR       (ELR),
    .ESR       (ESR),
    .ExcAck    (ExcAck),
    .ExtIAck   (ExtIAck),
`ifdef EXC_CAUSE_COUNT_EN
    .UndefCount(UndefCount),
    .IrqCount  (IrqCount),
`endif
    .InHandler (InHandler)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    NotAnInstr = 0; ExtIRQ = 0; ERet = 0; PC_E = '0;
    reset = 1'b1;
    #1;
    total++;
    if (ctl !== 6'b000000) begin
      bad++; $display("FAIL reset_ctl got=%b want=%b", ctl, 6'b000000);
    end
    total++;
    if (ESR !== 4'b0000 || ELR !== 64'h0) begin
      bad++; $display("FAIL reset_regs got esr=%h elr=%h want 0/0", ESR, ELR);
    end
    total++;
    if (ExcVector !== 64'hD8) begin
      bad++; $display("FAIL exc_vector got=%h want=%h", ExcVector, 64'hD8);
    end
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_undef();
    NotAnInstr = 1; PC_E = 64'h40;
    step();
    NotAnInstr = 0;
    total++;
    if (ESR !== 4'b0010 || ELR !== 64'h40) begin
      bad++; $display("FAIL undef_capture got esr=%h elr=%h want 2/40", ESR, ELR);
    end
    for (int i = 1; i <= F; i++) begin
      total++;
      if (ctl !== 6'b100000) begin
        bad++; $display("FAIL undef_flush%0d got=%b want=%b", i, ctl, 6'b100000);
      end
      step();
    end
    total++;
    if (ctl !== 6'b110100) begin
      bad++; $display("FAIL undef_vector got=%b want=%b", ctl, 6'b110100);
    end
    step();
    total++;
    if (ctl !== 6'b000001) begin
      bad++; $display("FAIL undef_handler got=%b want=%b", ctl, 6'b000001);
    end
  endtask

  task automatic test_eret();
    ERet = 1;
    step();
    ERet = 0;
    total++;
    if (ctl !== 6'b101001 || ERetPC !== 64'h40) begin
      bad++; $display("FAIL eret_return got ctl=%b pc=%h want 101001/40", ctl, ERetPC);
    end
    step();
    total++;
    if (ctl !== 6'b000000) begin
      bad++; $display("FAIL eret_idle got=%b want=%b", ctl, 6'b000000);
    end
    ERet = 1;
    step();
    ERet = 0;
    total++;
    if (ctl !== 6'b000000 || ESR !== 4'b0010 || ELR !== 64'h40) begin
      bad++; $display("FAIL eret_in_idle got ctl=%b esr=%h elr=%h want 0/2/40", ctl, ESR, ELR);
    end
  endtask

  task automatic test_irq();
    ExtIRQ = 1; PC_E = 64'h100;
    step();
    total++;
    if (ctl !== 6'b100000 || ESR !== 4'b0001 || ELR !== 64'h100) begin
      bad++; $display("FAIL irq_capture got ctl=%b esr=%h elr=%h want 100000/1/100", ctl, ESR, ELR);
    end
    step();
    step();
    total++;
    if (ExtIAck !== 1'b0) begin
      bad++; $display("FAIL irq_ack_early got=%b want=0", ExtIAck);
    end
    step();
    total++;
    if (ctl !== 6'b110110) begin
      bad++; $display("FAIL irq_vector got=%b want=%b", ctl, 6'b110110);
    end
    ExtIRQ = 0;
    step();
    total++;
    if (ctl !== 6'b000001) begin
      bad++; $display("FAIL irq_handler got=%b want=%b", ctl, 6'b000001);
    end
    ERet = 1;
    step();
    ERet = 0;
    step();
  endtask

  task automatic test_simultaneous();
    NotAnInstr = 1; ExtIRQ = 1; PC_E = 64'h200;
    step();
    NotAnInstr = 0; PC_E = 64'h300;
    total++;
    if (ESR !== 4'b0010 || ELR !== 64'h200) begin
      bad++; $display("FAIL simul_first got esr=%h elr=%h want 2/200", ESR, ELR);
    end
    for (int i = 0; i < F; i++) step();
    total++;
    if (ctl !== 6'b110100) begin
      bad++; $display("FAIL simul_vector got=%b want=%b", ctl, 6'b110100);
    end
    step();
    total++;
    if (ctl !== 6'b000001 || ESR !== 4'b0010) begin
      bad++; $display("FAIL simul_masked got ctl=%b esr=%h want 000001/2", ctl, ESR);
    end
    ERet = 1;
    step();
    ERet = 0;
    step();
    total++;
    if (ctl !== 6'b000000) begin
      bad++; $display("FAIL simul_idle got=%b want=%b", ctl, 6'b000000);
    end
    step();
    total++;
    if (ctl !== 6'b100000 || ESR !== 4'b0001 || ELR !== 64'h300) begin
      bad++; $display("FAIL simul_second got ctl=%b esr=%h elr=%h want 100000/1/300", ctl, ESR, ELR);
    end
    for (int i = 0; i < F; i++) step();
    total++;
    if (ctl !== 6'b110110) begin
      bad++; $display("FAIL simul_vector2 got=%b want=%b", ctl, 6'b110110);
    end
    ExtIRQ = 0;
    step();
    ERet = 1;
    step();
    ERet = 0;
    step();
  endtask

  task automatic test_reset_mid_flush();
    NotAnInstr = 1; PC_E = 64'h500;
    step();
    NotAnInstr = 0;
    step();
    total++;
    if (ctl !== 6'b100000) begin
      bad++; $display("FAIL rst_pre got=%b want=%b", ctl, 6'b100000);
    end
    reset = 1'b1;
    #1;
    total++;
    if (ctl !== 6'b000000 || ESR !== 4'b0000 || ELR !== 64'h0) begin
      bad++; $display("FAIL rst_mid got ctl=%b esr=%h elr=%h want 0/0/0", ctl, ESR, ELR);
    end
    step();
    reset = 1'b0;
    step();
    step();
    total++;
    if (ctl !== 6'b000000) begin
      bad++; $display("FAIL rst_release got=%b want=%b", ctl, 6'b000000);
    end
  endtask

`ifdef EXC_CAUSE_COUNT_EN
  task automatic test_counters();
    logic [15:0] base;
    base = IrqCount;
    for (int n = 0; n < 3; n++) begin
      ExtIRQ = 1; PC_E = 64'h1000;
      for (int i = 0; i <= F; i++) step();
      ExtIRQ = 0;
      step();
      ERet = 1;
      step();
      ERet = 0;
      step();
    end
    total++;
    if (IrqCount !== base + 16'd3) begin
      bad++; $display("FAIL irq_count got=%0d want=%0d", IrqCount, base + 16'd3);
    end
    dut.irq_count_q = 16'hFFFF;
    ExtIRQ = 1;
    for (int i = 0; i <= F; i++) step();
    ExtIRQ = 0;
    step();
    ERet = 1;
    step();
    ERet = 0;
    step();
    total++;
    if (IrqCount !== 16'hFFFF) begin
      bad++; $display("FAIL irq_count_sat got=%h want=ffff", IrqCount);
    end
  endtask
`endif

  // Model tracks k = cycles since capture: 0 idle, 1..F flush, F+1 vector,
  // F+2 handler, F+3 return.
  task automatic test_random();
    int          k;
    logic [3:0]  m_esr;
    logic [63:0] m_elr;
    logic [5:0]  exp;
    int          m_undef, m_irq;
    reset = 1'b1;
    #1;
    reset = 1'b0;
    k = 0; m_esr = 4'b0000; m_elr = '0; m_undef = 0; m_irq = 0;
    NotAnInstr = 0; ExtIRQ = 0; ERet = 0;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 149) == 0) begin
        reset = 1'b1;
        #1;
        reset = 1'b0;
        k = 0; m_esr = 4'b0000; m_elr = '0; m_undef = 0; m_irq = 0;
      end
      NotAnInstr = ($urandom_range(0, 5) == 0);
      if (!ExtIRQ) ExtIRQ = ($urandom_range(0, 7) == 0);
      ERet = ($urandom_range(0, 3) == 0);
      PC_E = {$urandom, $urandom};
      @(posedge clk);
      if (k == 0) begin
        if (NotAnInstr || ExtIRQ) begin
          m_esr = NotAnInstr ? 4'b0010 : 4'b0001;
          m_elr = PC_E;
          if (NotAnInstr) m_undef++; else m_irq++;
          k = 1;
        end
      end else if (k <= F + 1) begin
        k++;
      end else if (k == F + 2) begin
        if (ERet) k = F + 3;
      end else begin
        k = 0;
      end
      #1;
      exp = {((k >= 1 && k <= F + 1) || k == F + 3), (k == F + 1), (k == F + 3),
             (k == F + 1), (k == F + 1 && m_esr == 4'b0001), (k >= F + 2)};
      total++;
      if (ctl !== exp) begin
        bad++; $display("FAIL rand_ctl cyc=%0d got=%b want=%b", c, ctl, exp);
      end
      total++;
      if (ESR !== m_esr || ELR !== m_elr || ERetPC !== m_elr) begin
        bad++; $display("FAIL rand_regs cyc=%0d got esr=%h elr=%h erpc=%h want %h/%h",
                        c, ESR, ELR, ERetPC, m_esr, m_elr);
      end
`ifdef EXC_CAUSE_COUNT_EN
      total++;
      if (UndefCount !== 16'(m_undef) || IrqCount !== 16'(m_irq)) begin
        bad++; $display("FAIL rand_counts cyc=%0d got=%0d/%0d want=%0d/%0d",
                        c, UndefCount, IrqCount, m_undef, m_irq);
      end
`endif
      // Interrupt source releases its request once acknowledged.
      if (exp[1]) ExtIRQ = 0;
    end
    NotAnInstr = 0; ExtIRQ = 0; ERet = 0;
  endtask

  initial begin
    test_reset();
    test_undef();
    test_eret();
    test_irq();
    test_simultaneous();
    test_reset_mid_flush();
`ifdef EXC_CAUSE_COUNT_EN
    test_counters();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
